// File: rtl/regfile_mp_if.sv
// Register-file bus: decode-side reads/issue plus writeback-side write port.
// Port k of R_ADDR/R_DATA occupies slice [k*AW +: AW] / [k*XLEN +: XLEN].
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   R_ADDR;
  logic [NRD*XLEN-1:0] R_DATA;
  logic [NRD-1:0]      R_BUSY;
  logic [AW-1:0]       RD;
  logic [XLEN-1:0]     RD_DATA;
  logic                WRITE_ENABLE;
  logic                ISSUE_EN;
  logic [AW-1:0]       ISSUE_RD;
  logic                READY;

  modport master (
    output R_ADDR, RD, RD_DATA, WRITE_ENABLE, ISSUE_EN, ISSUE_RD,
    input  R_DATA, R_BUSY, READY
  );

  modport slave (
    input  R_ADDR, RD, RD_DATA, WRITE_ENABLE, ISSUE_EN, ISSUE_RD,
    output R_DATA, R_BUSY, READY
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port RV32I register file with post-reset clear sequencer and busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  regfile_mp_if.slave   bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state, state_nxt;
  logic [AW:0]         cnt, cnt_nxt;
  logic                ready;
  logic                wr_acc, iss_acc;
  logic [XLEN-1:0]     mem [NREGS];
  logic [NREGS-1:0]    busy, busy_nxt;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;

  assign ready   = (state == RUN);
  assign wr_acc  = bus.WRITE_ENABLE && (bus.RD != '0) && ready;
  assign iss_acc = bus.ISSUE_EN && (bus.ISSUE_RD != '0) && ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == LAST) state_nxt = RUN;
    end
  end

  // Storage carries no reset; the clear sequence zeroes it one entry per cycle.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) mem[cnt[AW-1:0]] <= '0;
    else if (wr_acc)    mem[bus.RD]      <= bus.RD_DATA;
  end

  // Issue is applied after the writeback clear so a same-register collision leaves busy set.
  always_comb begin
    busy_nxt = busy;
    if (wr_acc)  busy_nxt[bus.RD]       = 1'b0;
    if (iss_acc) busy_nxt[bus.ISSUE_RD] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) busy <= '0;
    else       busy <= busy_nxt;
  end

  always_comb begin
    logic [AW-1:0] ra;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.R_ADDR[k*AW +: AW];
      if (ready && (ra != '0)) begin
        rdata[k*XLEN +: XLEN] = mem[ra];
        rbusy[k]              = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (ra == bus.RD)) begin
          rdata[k*XLEN +: XLEN] = bus.RD_DATA;
          rbusy[k]              = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.R_DATA = rdata;
  assign bus.R_BUSY = rbusy;
  assign bus.READY  = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32/2-port instance plus a 64-bit 16x3 instance.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) b1();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) b2();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut1 (.CLK(clk), .RESET(rst), .bus(b1));
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut2 (.CLK(clk), .RESET(rst), .bus(b2));

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ir;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;   // expected without forwarding
    logic [31:0] d1;
    logic        s0;
    logic        s1;
    logic [31:0] f0;   // expected with forwarding
    logic [31:0] f1;
    logic        g0;
    logic        g1;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle1();
    b1.WRITE_ENABLE = 1'b0; b1.RD = '0; b1.RD_DATA = '0;
    b1.ISSUE_EN = 1'b0; b1.ISSUE_RD = '0;
  endtask

  // Counts edges after reset release until each READY rises; checks port0 reads 0 meanwhile.
  task automatic wait_ready(output int n1, output int n2);
    n1 = 0; n2 = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n2 == 0 && b2.READY) n2 = n;
      if (b1.READY) begin n1 = n; break; end
      chk("clear_rdata0", {32'b0, b1.R_DATA[31:0]}, 64'd0);
    end
    if (n1 == 0) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n1, n2;
    rst = 1'b1;
    idle1();
    b1.R_ADDR = {5'd0, 5'd5};
    b2.R_ADDR = '0; b2.RD = '0; b2.RD_DATA = '0;
    b2.WRITE_ENABLE = 1'b0; b2.ISSUE_EN = 1'b0; b2.ISSUE_RD = '0;

    tv[0]  = '{1, 7, 32'hDEADBEEF, 0, 0, 7, 7, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tv[2]  = '{1, 0, 32'h12345678, 1, 0, 0, 7, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 0, 1, 3, 3, 7, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0};
    tv[5]  = '{0, 0, 0, 0, 0, 3, 7, 0, 32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF, 1, 0};
    tv[6]  = '{1, 3, 32'h33, 0, 0, 3, 3, 0, 0, 1, 1, 32'h33, 32'h33, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 3, 3, 32'h33, 32'h33, 0, 0, 32'h33, 32'h33, 0, 0};
    tv[8]  = '{1, 3, 32'h55, 1, 3, 3, 7, 32'h33, 32'hDEADBEEF, 0, 0, 32'h55, 32'hDEADBEEF, 0, 0};
    tv[9]  = '{0, 0, 0, 0, 0, 3, 3, 32'h55, 32'h55, 1, 1, 32'h55, 32'h55, 1, 1};
    tv[10] = '{1, 3, 32'h66, 1, 9, 9, 3, 0, 32'h55, 0, 1, 0, 32'h66, 0, 0};
    tv[11] = '{0, 0, 0, 0, 0, 9, 3, 0, 32'h66, 1, 0, 0, 32'h66, 1, 0};
    tv[12] = '{1, 9, 32'h99, 0, 0, 9, 1, 0, 0, 1, 0, 32'h99, 0, 0, 0};
    tv[13] = '{0, 0, 0, 0, 0, 9, 9, 32'h99, 32'h99, 0, 0, 32'h99, 32'h99, 0, 0};

    // Reset state
    @(posedge clk); #1;
    chk("rst_ready",  {63'b0, b1.READY}, 64'd0);
    chk("rst_rdata",  {32'b0, b1.R_DATA[31:0]}, 64'd0);
    chk("rst_rbusy",  {62'b0, b1.R_BUSY}, 64'd0);
    chk("rst_ready2", {63'b0, b2.READY}, 64'd0);

    rst = 1'b0;
    wait_ready(n1, n2);
    chk("clear_lat32", 64'(n1), 64'd32);
    chk("clear_lat16", 64'(n2), 64'd16);

    // Wide instance: three distinct registers read concurrently
    b2.WRITE_ENABLE = 1'b1; b2.RD = 4'd2;  b2.RD_DATA = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    b2.RD = 4'd9;  b2.RD_DATA = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk); #1;
    b2.RD = 4'd15; b2.RD_DATA = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    b2.WRITE_ENABLE = 1'b0;
    b2.R_ADDR = {4'd2, 4'd9, 4'd15};
    #2;
    chk("wide_p0", b2.R_DATA[63:0],    64'h0123_4567_89AB_CDEF);
    chk("wide_p1", b2.R_DATA[127:64],  64'hAAAA_BBBB_CCCC_DDDD);
    chk("wide_p2", b2.R_DATA[191:128], 64'h1111_2222_3333_4444);

    // Pre-fill x5, then reset must clear it
    @(posedge clk); #1;
    b1.WRITE_ENABLE = 1'b1; b1.RD = 5'd5; b1.RD_DATA = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    idle1();
    #2;
    chk("prefill_x5", {32'b0, b1.R_DATA[31:0]}, 64'hA5A5_5A5A);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", {63'b0, b1.READY}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(n1, n2);
    chk("reclear_lat32", 64'(n1), 64'd32);
    chk("reclear_x5", {32'b0, b1.R_DATA[31:0]}, 64'd0);

    // Table-driven functional vectors
    for (int i = 0; i < 14; i++) begin
      b1.WRITE_ENABLE = tv[i].we; b1.RD = tv[i].rd; b1.RD_DATA = tv[i].wd;
      b1.ISSUE_EN = tv[i].ie; b1.ISSUE_RD = tv[i].ir;
      b1.R_ADDR = {tv[i].a1, tv[i].a0};
      #2;
`ifdef REGFILE_BYPASS_EN
      chk($sformatf("v%0d_d0", i), {32'b0, b1.R_DATA[31:0]},  {32'b0, tv[i].f0});
      chk($sformatf("v%0d_d1", i), {32'b0, b1.R_DATA[63:32]}, {32'b0, tv[i].f1});
      chk($sformatf("v%0d_b0", i), {63'b0, b1.R_BUSY[0]}, {63'b0, tv[i].g0});
      chk($sformatf("v%0d_b1", i), {63'b0, b1.R_BUSY[1]}, {63'b0, tv[i].g1});
`else
      chk($sformatf("v%0d_d0", i), {32'b0, b1.R_DATA[31:0]},  {32'b0, tv[i].d0});
      chk($sformatf("v%0d_d1", i), {32'b0, b1.R_DATA[63:32]}, {32'b0, tv[i].d1});
      chk($sformatf("v%0d_b0", i), {63'b0, b1.R_BUSY[0]}, {63'b0, tv[i].s0});
      chk($sformatf("v%0d_b1", i), {63'b0, b1.R_BUSY[1]}, {63'b0, tv[i].s1});
`endif
      @(posedge clk); #1;
    end
    idle1();

    // Reset at CNT = 10, with writes and issues to x4 held through the clear
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    b1.WRITE_ENABLE = 1'b1; b1.RD = 5'd4; b1.RD_DATA = 32'h4444_4444;
    b1.ISSUE_EN = 1'b1; b1.ISSUE_RD = 5'd4;
    b1.R_ADDR = {5'd4, 5'd4};
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(n1, n2);
    idle1();
    chk("midclear_lat32", 64'(n1), 64'd32);
    #1;
    chk("midclear_x4", {32'b0, b1.R_DATA[63:32]}, 64'd0);
    chk("midclear_busy4", {63'b0, b1.R_BUSY[1]}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RV32I core, and the successor to the single-cycle two-port register file. It has a clocked write port and NRD asynchronous read ports. A counter-driven clear sequencer zeroes storage after reset, and a per-register busy scoreboard lets the decode stage detect pending writebacks. It sits between decode (reads, issue) and writeback (write).

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of registers; power of two, ≥ 2. AW = $clog2(NREGS).
- NRD, 2: number of read ports, ≥ 1.

- CLK  in  1  rising-edge clock for all state.
- RESET  in  1  asynchronous, active-high reset.
- R_ADDR  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- R_DATA  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- R_BUSY  out  NRD  scoreboard busy bit of the register addressed on each port.
- RD  in  AW  write address.
- RD_DATA  in  XLEN  write data.
- WRITE_ENABLE  in  1  write strobe, sampled at the CLK edge.
- ISSUE_EN  in  1  marks ISSUE_RD as having a pending write.
- ISSUE_RD  in  AW  destination register of the instruction being issued.
- READY  out  1  high once the clear sequence has completed.

## Operation
Sequencer states:
- CLEAR:
  - Each cycle writes 0 to entry CNT, then CNT increments.
  - In the cycle with CNT == NREGS-1 the state moves to RUN at the next edge.
- RUN: normal operation. The sequencer stays in RUN until RESET.

RESET behaviour:
- Forces state to CLEAR, CNT = 0, READY = 0 and all busy bits to 0, asynchronously.
- Storage contents are not reset directly; the clear sequence zeroes them.

Reads:
- Combinational from storage.
- Address 0 always returns 0 with busy 0.
- While READY = 0, every port returns 0 with busy 0.

Writes:
- Storage[RD] <= RD_DATA at the edge when WRITE_ENABLE = 1, RD != 0 and READY = 1.
- All other writes are dropped silently.

Scoreboard (NREGS bits, bit 0 tied to 0):
- ISSUE_EN = 1, ISSUE_RD != 0 and READY = 1 sets busy[ISSUE_RD] at the edge.
- A write accepted to RD clears busy[RD] at the edge.
- If issue and write target the same register in the same cycle, set wins: the data is written and the busy bit ends at 1.
- Issue and write to different registers both take effect.
- ISSUE_EN while READY = 0 is ignored.

Arithmetic and addressing:
- CNT is AW+1 bits wide; no wrap occurs because the sequencer exits at NREGS-1.
- An R_ADDR value must be < NREGS, which is always true when NREGS is a power of two.

## Timing
- Reset values: READY = 0, R_DATA = 0 and R_BUSY = 0 on all ports, state CLEAR.
- Clear latency: READY rises exactly NREGS cycles after the first CLK edge following RESET deassertion.
- RESET asserted mid-operation, including mid-clear, restarts the full clear from CNT = 0.
- Read latency is 0 cycles, combinational from R_ADDR.
- Without bypass, a written value becomes visible on reads in the cycle after the write edge.
- Busy set or clear becomes visible in the cycle after the edge.
- All ports are independent; any number may read the same address.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When WRITE_ENABLE = 1, RD != 0, READY = 1 and R_ADDR[k] == RD, port k returns RD_DATA in the same cycle.
  - In that case R_BUSY[k] = 0, even if the busy bit is currently set.
  - Write-port-to-read-port forwarding is purely combinational.
- REGFILE_BYPASS_EN undefined:
  - No forwarding; reads always reflect registered storage and the registered busy bits.

## Test plan
- Reset then clear: pre-fill storage via writes, pulse RESET, hold R_ADDR = 5 → READY low for exactly 32 cycles, then rises; R_DATA = 0 throughout and after.
- Write/read: write 0xDEADBEEF to x7 with R_ADDR port0 = 7 and port1 = 7 → both ports read 0xDEADBEEF from the next cycle. With the macro defined, they read it in the same cycle.
- x0: write 0x12345678 to x0 and issue x0 → R_DATA = 0 and R_BUSY = 0 on a read of x0.
- Scoreboard: issue x3, then write x3 two cycles later → R_BUSY = 1 for those cycles, 0 after the write edge. Same-cycle issue and write of x3 → busy stays 1 and data is updated.
- Reset mid-clear: assert RESET at CNT = 10 → READY rises 32 cycles after the release; writes during CLEAR are dropped (a read of x4 returns 0).
- Parameters: XLEN = 64, NREGS = 16, NRD = 3, three distinct addresses written then read concurrently → each port returns its own value; READY rises 16 cycles after reset release.
